// File: rtl/scandbl_reader_pkg.sv
// -----------------------------------------------------------------------------
// scandbl_reader_pkg
// Shared definitions for the scan-doubler line-buffer read side (and the write
// side sequencer that feeds it): FSM state encoding and the default horizontal
// timing of one output line, all in output-pixel periods.
// -----------------------------------------------------------------------------
package scandbl_reader_pkg;

  // Width of the pixel-period counter and of the line-buffer read address.
  localparam int CNT_W = 10;

  // Default output-line timing (640x480 @ 60 Hz horizontal, pixel periods).
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  // Read-side sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACTIVE = 3'd1,
    ST_FP     = 3'd2,
    ST_SYNC   = 3'd3,
    ST_BP     = 3'd4
  } state_t;

endpackage : scandbl_reader_pkg

// File: rtl/scandbl_reader.sv
// -----------------------------------------------------------------------------
// scandbl_reader
// Read side of a line-doubling scan converter. Every stored input line is read
// out twice (pass 0, then pass 1) with full horizontal timing, so the output
// runs at twice the input line rate. Lines are handed over by the writer via a
// pending slot; if no fresh line is waiting when one is needed the line is
// blanked (underrun), and a newer line arriving on top of an unread one
// replaces it (overrun).
//
// Ports
//   clk        system clock, all state changes on its rising edge
//   rst_n      asynchronous active-low reset
//   ce         output-pixel clock enable (one pixel period per ce-high cycle)
//   line_done  one-clk pulse: a complete line now sits in bank line_bank
//   line_bank  bank completed by the writer, sampled with line_done
//   clr_flags  synchronous clear of underrun/overrun (a coincident set wins)
//   rd_bank    bank currently being read
//   rd_addr    read address into the line buffer (0 outside ACTIVE)
//   hsync      horizontal sync, active-high
//   de         display enable, one ce behind rd_addr to match buffer latency
//   pass       0 = first read of the stored line, 1 = repeat read
//   underrun   sticky: a line started with no fresh line pending
//   overrun    sticky: line_done arrived while a line was still pending
//   dbg_state  current sequencer state, for observation only
//
// Handshake: line_done/line_bank form a pulse-only transfer with no
// back-pressure. The pending slot accepts on every clk; the sequencer takes it
// on a ce edge at a line start. A take and a new line_done in the same clk
// leave the slot full with the new bank and do not count as an overrun.
// -----------------------------------------------------------------------------
module scandbl_reader
  import scandbl_reader_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             line_done,
  input  logic             line_bank,
  input  logic             clr_flags,
  output logic             rd_bank,
  output logic [CNT_W-1:0] rd_addr,
  output logic             hsync,
  output logic             de,
  output logic             pass,
  output logic             underrun,
  output logic             overrun,
  output state_t           dbg_state
);

  // Terminal counts: a state of length N ends when the counter reads N-1.
  localparam logic [CNT_W-1:0] LAST_ACTIVE = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] LAST_FP     = CNT_W'(H_FP - 1);
  localparam logic [CNT_W-1:0] LAST_SYNC   = CNT_W'(H_SYNC - 1);
  localparam logic [CNT_W-1:0] LAST_BP     = CNT_W'(H_BP - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rd_bank_q, rd_bank_d;
  logic             pass_q, pass_d;
  logic             blank_q, blank_d;   // current line is an underrun line
  logic             de_q, de_d;
  logic             pending_q, pend_bank_q;
  logic             underrun_q, overrun_q;
  logic             consume;            // pending slot taken this clk
  logic             under_set;

  // ---------------------------------------------------------------------------
  // Sequencer state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rd_bank_q <= 1'b0;
      pass_q    <= 1'b0;
      blank_q   <= 1'b0;
      de_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_bank_q <= rd_bank_d;
      pass_q    <= pass_d;
      blank_q   <= blank_d;
      de_q      <= de_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_bank_d = rd_bank_q;
    pass_d    = pass_q;
    blank_d   = blank_q;
    de_d      = de_q;
    consume   = 1'b0;
    under_set = 1'b0;

    if (ce) begin
      // de is the ACTIVE indication of the previous pixel period.
      de_d  = (state_q == ST_ACTIVE) && !blank_q;
      cnt_d = cnt_q + 1'b1;
      unique case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (pending_q) begin
            state_d   = ST_ACTIVE;
            pass_d    = 1'b0;
            rd_bank_d = pend_bank_q;
            blank_d   = 1'b0;
            consume   = 1'b1;
          end
        end
        ST_ACTIVE: if (cnt_q == LAST_ACTIVE) begin
          state_d = ST_FP;
          cnt_d   = '0;
        end
        ST_FP: if (cnt_q == LAST_FP) begin
          state_d = ST_SYNC;
          cnt_d   = '0;
        end
        ST_SYNC: if (cnt_q == LAST_SYNC) begin
          state_d = ST_BP;
          cnt_d   = '0;
        end
        ST_BP: if (cnt_q == LAST_BP) begin
          // Timing never stops once running; only the line source changes.
          state_d = ST_ACTIVE;
          cnt_d   = '0;
          blank_d = 1'b0;
          if (!pass_q) begin
            pass_d = 1'b1;
          end else if (pending_q) begin
            pass_d    = 1'b0;
            rd_bank_d = pend_bank_q;
            consume   = 1'b1;
          end else begin
            pass_d    = 1'b0;
            blank_d   = 1'b1;
            under_set = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Pending slot and sticky flags: run on every clk, independent of ce.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q   <= 1'b0;
      pend_bank_q <= 1'b0;
      underrun_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (line_done) begin
        pending_q   <= 1'b1;
        pend_bank_q <= line_bank;
      end else if (consume) begin
        pending_q <= 1'b0;
      end

      if (line_done && pending_q && !consume) overrun_q <= 1'b1;
      else if (clr_flags)                     overrun_q <= 1'b0;

      if (under_set)      underrun_q <= 1'b1;
      else if (clr_flags) underrun_q <= 1'b0;
    end
  end

  assign rd_addr   = (state_q == ST_ACTIVE) ? cnt_q : '0;
  assign hsync     = (state_q == ST_SYNC);
  assign de        = de_q;
  assign rd_bank   = rd_bank_q;
  assign pass      = pass_q;
  assign underrun  = underrun_q;
  assign overrun   = overrun_q;
  assign dbg_state = state_q;

endmodule : scandbl_reader

// File: tb/tb_scandbl_reader.sv
// -----------------------------------------------------------------------------
// tb_scandbl_reader
// Self-checking bench for scandbl_reader with default 640/16/96/48 timing.
// A position-based line model (pixel index within an 800-period line) runs
// alongside the DUT and is compared on every clk; directed tests add literal
// expectations on sync widths, periods, bank/pass sequences and flags.
// -----------------------------------------------------------------------------
module tb_scandbl_reader;
  import scandbl_reader_pkg::*;

  localparam int HA    = DEF_H_ACTIVE;
  localparam int HF    = DEF_H_FP;
  localparam int HS    = DEF_H_SYNC;
  localparam int HB    = DEF_H_BP;
  localparam int TOTAL = HA + HF + HS + HB;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ce;
  logic       line_done = 1'b0;
  logic       line_bank = 1'b0;
  logic       clr_flags = 1'b0;
  logic       rd_bank;
  logic [9:0] rd_addr;
  logic       hsync, de, pass, underrun, overrun;
  state_t     dbg_state;
  logic       ce_alt = 1'b0;
  logic       chk_en = 1'b0;

  initial forever #5 clk = ~clk;

  scandbl_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .line_done (line_done),
    .line_bank (line_bank),
    .clr_flags (clr_flags),
    .rd_bank   (rd_bank),
    .rd_addr   (rd_addr),
    .hsync     (hsync),
    .de        (de),
    .pass      (pass),
    .underrun  (underrun),
    .overrun   (overrun),
    .dbg_state (dbg_state)
  );

  // ce is either constantly high or high on alternate clks.
  initial begin
    ce = 1'b1;
    forever begin
      @(negedge clk);
      ce = ce_alt ? ~ce : 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard counters and check helper
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: a line is a position 0..TOTAL-1; active when pos < HA,
  // sync when HA+HF <= pos < HA+HF+HS. Lines are back to back once started.
  // ---------------------------------------------------------------------------
  bit m_run, m_pass, m_bank, m_blank, m_pend, m_pbank, m_under, m_over, m_de;
  int m_pos;

  task automatic model_step();
    bit took, u_set, o_set;
    took = 0; u_set = 0; o_set = 0;
    if (!rst_n) begin
      m_run = 0; m_pos = 0; m_pass = 0; m_bank = 0; m_blank = 0;
      m_pend = 0; m_pbank = 0; m_under = 0; m_over = 0; m_de = 0;
    end else begin
      if (ce) begin
        m_de = m_run && (m_pos < HA) && !m_blank;
        if (!m_run) begin
          if (m_pend) begin
            m_run = 1; m_pos = 0; m_pass = 0; m_bank = m_pbank; m_blank = 0; took = 1;
          end
        end else if (m_pos == TOTAL - 1) begin
          m_pos = 0;
          m_blank = 0;
          if (!m_pass) m_pass = 1;
          else if (m_pend) begin
            m_pass = 0; m_bank = m_pbank; took = 1;
          end else begin
            m_pass = 0; m_blank = 1; u_set = 1;
          end
        end else begin
          m_pos++;
        end
      end
      if (line_done) begin
        if (m_pend && !took) o_set = 1;
        m_pend = 1;
        m_pbank = line_bank;
      end else if (took) begin
        m_pend = 0;
      end
      if (u_set) m_under = 1; else if (clr_flags) m_under = 0;
      if (o_set) m_over = 1;  else if (clr_flags) m_over = 0;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  // Compare process: every clk, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("rd_addr",  int'(rd_addr),  (m_run && m_pos < HA) ? m_pos : 0);
      chk("hsync",    int'(hsync),    int'(m_run && m_pos >= HA + HF && m_pos < HA + HF + HS));
      chk("de",       int'(de),       int'(m_de));
      chk("rd_bank",  int'(rd_bank),  int'(m_bank));
      chk("pass",     int'(pass),     int'(m_pass));
      chk("underrun", int'(underrun), int'(m_under));
      chk("overrun",  int'(overrun),  int'(m_over));
    end
  end

  // ---------------------------------------------------------------------------
  // Measurement monitor (feeds the literal checks)
  // ---------------------------------------------------------------------------
  int rise_q[$], width_q[$], rise_pass_q[$], rise_bank_q[$], de_rise_addr_q[$];
  int hs_run = 0, de_cnt = 0, a639_cnt = 0, nz_addr_cnt = 0;
  logic hs_prev = 1'b0, de_prev = 1'b0;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (hsync && !hs_prev) begin
      rise_q.push_back(cyc);
      rise_pass_q.push_back(int'(pass));
      rise_bank_q.push_back(int'(rd_bank));
      hs_run = 0;
    end
    if (hsync) hs_run++;
    if (!hsync && hs_prev) width_q.push_back(hs_run);
    if (de && !de_prev) de_rise_addr_q.push_back(int'(rd_addr));
    if (de) de_cnt++;
    if (rd_addr == 10'd639) a639_cnt++;
    if (rd_addr != 10'd0) nz_addr_cnt++;
    hs_prev = hsync;
    de_prev = de;
  end

  task automatic clear_meas();
    rise_q.delete(); width_q.delete(); rise_pass_q.delete();
    rise_bank_q.delete(); de_rise_addr_q.delete();
    de_cnt = 0; a639_cnt = 0; nz_addr_cnt = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ld(input logic b);
    @(negedge clk);
    line_done = 1'b1;
    line_bank = b;
    @(negedge clk);
    line_done = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
  endtask

  // Reset edges are kept 2 time units off the clock edges.
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    line_done = 1'b0;
    clr_flags = 1'b0;
    wait_clk(3);
    #2 rst_n = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_addr"},  int'(rd_addr),  0);
    chk({tag, "_rd_bank"},  int'(rd_bank),  0);
    chk({tag, "_hsync"},    int'(hsync),    0);
    chk({tag, "_de"},       int'(de),       0);
    chk({tag, "_pass"},     int'(pass),     0);
    chk({tag, "_underrun"}, int'(underrun), 0);
    chk({tag, "_overrun"},  int'(overrun),  0);
    chk({tag, "_state"},    int'(dbg_state), int'(ST_IDLE));
  endtask

  // ---------------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------------
  initial begin
    // Reset state.
    wait_clk(3);
    chk_all_zero("reset");
    #2 rst_n = 1'b1;
    chk_en = 1'b1;

    // Test 1 + 3: one line_done (bank 1), line read twice, third line blanked.
    clear_meas();
    pulse_ld(1'b1);
    wait_clk(1610);
    chk("t1_rd_bank", int'(rd_bank), 1);
    chk("t1_hs_count", rise_q.size(), 2);
    if (rise_q.size() >= 2) chk("t1_hs_period", rise_q[1] - rise_q[0], 800);
    if (width_q.size() >= 2) begin
      chk("t1_hs_width0", width_q[0], 96);
      chk("t1_hs_width1", width_q[1], 96);
    end else chk("t1_hs_widths", width_q.size(), 2);
    chk("t1_addr639_count", a639_cnt, 2);
    chk("t1_de_count", de_cnt, 2 * 640);
    if (de_rise_addr_q.size() >= 1) chk("t1_de_rise_addr", de_rise_addr_q[0], 1);
    else chk("t1_de_rises", de_rise_addr_q.size(), 1);
    de_cnt = 0;
    wait_clk(790);
    chk("t3_de_count", de_cnt, 0);
    chk("t3_underrun", int'(underrun), 1);
    chk("t3_hs_count", rise_q.size(), 3);
    if (rise_q.size() >= 3) chk("t3_hs_period", rise_q[2] - rise_q[1], 800);
    pulse_clr();
    chk("t3_underrun_clr", int'(underrun), 0);

    // Test 2: line_done every 1600 clk, alternating banks.
    do_reset();
    clear_meas();
    for (int i = 0; i < 4; i++) begin
      pulse_ld(1'(i % 2));
      wait_clk(1598);
    end
    chk("t2_hs_count", rise_q.size(), 8);
    for (int i = 0; i < 8 && i < rise_q.size(); i++) begin
      chk($sformatf("t2_pass%0d", i), rise_pass_q[i], i % 2);
      chk($sformatf("t2_bank%0d", i), rise_bank_q[i], (i / 2) % 2);
    end
    chk("t2_underrun", int'(underrun), 0);
    chk("t2_overrun", int'(overrun), 0);

    // Test 4: overrun, newer bank wins, clear and set-wins-over-clear.
    do_reset();
    pulse_ld(1'b1);
    wait_clk(100);
    pulse_ld(1'b1);
    wait_clk(8);
    pulse_ld(1'b0);
    chk("t4_overrun", int'(overrun), 1);
    wait_clk(1700);
    chk("t4_rd_bank", int'(rd_bank), 0);
    chk("t4_pass", int'(pass), 0);
    pulse_clr();
    chk("t4_overrun_clr", int'(overrun), 0);
    pulse_ld(1'b1);
    chk("t4_no_overrun", int'(overrun), 0);
    @(negedge clk);
    line_done = 1'b1; line_bank = 1'b0; clr_flags = 1'b1;
    @(negedge clk);
    line_done = 1'b0; clr_flags = 1'b0;
    chk("t4_set_wins", int'(overrun), 1);
    pulse_clr();
    chk("t4_overrun_clr2", int'(overrun), 0);

    // line_done in the same clk the pending line is taken: no overrun.
    do_reset();
    @(negedge clk);
    line_done = 1'b1; line_bank = 1'b0;
    @(negedge clk);
    line_bank = 1'b1;
    @(negedge clk);
    line_done = 1'b0;
    chk("t7_overrun", int'(overrun), 0);
    chk("t7_rd_bank_first", int'(rd_bank), 0);
    wait_clk(1700);
    chk("t7_rd_bank_next", int'(rd_bank), 1);
    chk("t7_underrun", int'(underrun), 0);

    // Test 5: ce on alternate clks doubles every interval.
    do_reset();
    ce_alt = 1'b1;
    clear_meas();
    pulse_ld(1'b0);
    wait_clk(3300);
    if (width_q.size() >= 1) chk("t5_hs_width", width_q[0], 192);
    else chk("t5_hs_widths", width_q.size(), 1);
    if (rise_q.size() >= 2) chk("t5_hs_period", rise_q[1] - rise_q[0], 1600);
    else chk("t5_hs_count", rise_q.size(), 2);
    if (de_rise_addr_q.size() >= 1) chk("t5_de_rise_addr", de_rise_addr_q[0], 1);
    else chk("t5_de_rises", de_rise_addr_q.size(), 1);
    ce_alt = 1'b0;

    // Test 6: reset mid-line at rd_addr 300.
    do_reset();
    pulse_ld(1'b1);
    for (int i = 0; i < 2000 && rd_addr != 10'd300; i++) @(negedge clk);
    chk("t6_reach_300", int'(rd_addr), 300);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("t6_async");
    wait_clk(3);
    #2 rst_n = 1'b1;
    clear_meas();
    wait_clk(2000);
    chk("t6_quiet_hs", rise_q.size(), 0);
    chk("t6_quiet_de", de_cnt, 0);
    chk("t6_quiet_addr", nz_addr_cnt, 0);
    pulse_ld(1'b0);
    wait_clk(800);
    chk("t6_restart_hs", rise_q.size(), 1);
    chk("t6_restart_de", de_cnt, 640);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_scandbl_reader
